// File: rtl/vx_perf_ctr_bank_pkg.sv
// Shared types and constants for the performance counter bank.
// Optional feature macro used by vx_perf_ctr_bank: VX_PERF_SNAPSHOT_EN.
package vx_perf_ctr_bank_pkg;

   // Default counter width shared with the rest of the perf path
   localparam int unsigned PERF_CTR_BITS = 44;

   // Counters wrap unless an instance asks for saturation
   localparam bit PERF_CTR_SATURATE_DEFAULT = 1'b0;

   typedef logic [PERF_CTR_BITS-1:0] perf_ctr_t;

   // Read response payload at the default counter width
   typedef struct packed {
      perf_ctr_t data;
      logic      ovf;
   } perf_rd_rsp_t;

   // Channel index width; never narrower than one bit
   function automatic int unsigned ch_bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vx_perf_ctr_bank_cell.sv
// One performance counter with a sticky overflow flag.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous clear of counter and overflow (wins over enable)
//   enable       : accumulate incr this cycle
//   incr         : per-cycle increment, zero-extended into the counter
//   value, ovf   : registered counter value and sticky overflow flag
module vx_perf_ctr_bank_cell #(
   parameter int unsigned CTR_WIDTH  = 44,
   parameter int unsigned INCR_WIDTH = 4,
   parameter bit          SATURATE   = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  enable,
   input  logic [INCR_WIDTH-1:0] incr,
   output logic [CTR_WIDTH-1:0]  value,
   output logic                  ovf
);

   localparam int unsigned SUM_W = CTR_WIDTH + 1;

   logic [CTR_WIDTH-1:0] r_ctr;
   logic                 r_ovf;
   logic [SUM_W-1:0]     w_sum;

   // One extra bit catches the carry out of the counter
   assign w_sum = {1'b0, r_ctr} + SUM_W'(incr);

   // Counter and sticky overflow update
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ctr <= '0;
         r_ovf <= 1'b0;
      end else if (clear) begin
         r_ctr <= '0;
         r_ovf <= 1'b0;
      end else if (enable) begin
         if (w_sum[CTR_WIDTH]) begin
            r_ovf <= 1'b1;
            r_ctr <= SATURATE ? '1 : w_sum[CTR_WIDTH-1:0];
         end else begin
            r_ctr <= w_sum[CTR_WIDTH-1:0];
         end
      end
   end

   assign value = r_ctr;
   assign ovf   = r_ovf;

endmodule

// File: rtl/vx_perf_ctr_bank.sv
// Multi-channel performance event accumulator with a one-entry read port.
// Optional feature macro: VX_PERF_SNAPSHOT_EN (adds snap_req and a shadow
// bank; reads then return shadow contents instead of live counters).
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   enable, clear       : global count enable, synchronous clear of all counters
//   event_incr          : channel i increment at [i*INCR_WIDTH +: INCR_WIDTH]
//   snap_req            : capture live counters into the shadow bank (macro only)
//   rd_req_valid/_id    : read request and channel index
//   rd_req_ready        : combinational; high when the response slot is free
//   rd_rsp_valid/_data/_ovf/_ready : registered read response handshake
module vx_perf_ctr_bank
   import vx_perf_ctr_bank_pkg::*;
#(
   parameter  int unsigned NUM_CHANNELS = 8,
   parameter  int unsigned INCR_WIDTH   = 4,
   parameter  int unsigned CTR_WIDTH    = PERF_CTR_BITS,
   parameter  bit          SATURATE     = PERF_CTR_SATURATE_DEFAULT,
   localparam int unsigned CH_BITS      = ch_bits(NUM_CHANNELS)
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               enable,
   input  logic                               clear,
   input  logic [NUM_CHANNELS*INCR_WIDTH-1:0] event_incr,
`ifdef VX_PERF_SNAPSHOT_EN
   input  logic                               snap_req,
`endif
   input  logic                               rd_req_valid,
   input  logic [CH_BITS-1:0]                 rd_req_id,
   output logic                               rd_req_ready,
   output logic                               rd_rsp_valid,
   output logic [CTR_WIDTH-1:0]               rd_rsp_data,
   output logic                               rd_rsp_ovf,
   input  logic                               rd_rsp_ready
);

   localparam int unsigned ENT_W      = CTR_WIDTH + 1;
   localparam int unsigned RD_ENTRIES = 1 << CH_BITS;

   // Entries are packed as {ovf, value}
   logic [ENT_W-1:0]     w_live   [NUM_CHANNELS];
   logic [ENT_W-1:0]     w_src    [NUM_CHANNELS];
   logic [ENT_W-1:0]     w_rd_tab [RD_ENTRIES];
   logic                 w_accept;
   logic                 r_rsp_valid;
   logic [CTR_WIDTH-1:0] r_rsp_data;
   logic                 r_rsp_ovf;

   // Counter cells
   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
      logic [CTR_WIDTH-1:0] w_value;
      logic                 w_ovf;

      vx_perf_ctr_bank_cell #(
         .CTR_WIDTH  (CTR_WIDTH),
         .INCR_WIDTH (INCR_WIDTH),
         .SATURATE   (SATURATE)
      ) u_cell (
         .clk     (clk),
         .reset_n (reset_n),
         .clear   (clear),
         .enable  (enable),
         .incr    (event_incr[g*INCR_WIDTH +: INCR_WIDTH]),
         .value   (w_value),
         .ovf     (w_ovf)
      );

      assign w_live[g] = {w_ovf, w_value};
   end

`ifdef VX_PERF_SNAPSHOT_EN
   logic [ENT_W-1:0] r_shadow [NUM_CHANNELS];

   // Shadow captures pre-update live values, including pre-clear values
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CHANNELS; i++) r_shadow[i] <= '0;
      end else if (snap_req) begin
         for (int i = 0; i < NUM_CHANNELS; i++) r_shadow[i] <= w_live[i];
      end
   end

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_src
      assign w_src[g] = r_shadow[g];
   end
`else
   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_src
      assign w_src[g] = w_live[g];
   end
`endif

   // Full-range read table; ids past the last channel read as zero
   for (genvar g = 0; g < RD_ENTRIES; g++) begin : g_rd
      if (g < NUM_CHANNELS) begin : g_hit
         assign w_rd_tab[g] = w_src[g];
      end else begin : g_miss
         assign w_rd_tab[g] = '0;
      end
   end

   assign rd_req_ready = !r_rsp_valid || rd_rsp_ready;
   assign w_accept     = rd_req_valid && rd_req_ready;

   // One-entry response register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_rsp_valid              <= 1'b1;
         {r_rsp_ovf, r_rsp_data}  <= w_rd_tab[rd_req_id];
      end else if (rd_rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign rd_rsp_valid = r_rsp_valid;
   assign rd_rsp_data  = r_rsp_data;
   assign rd_rsp_ovf   = r_rsp_ovf;

endmodule

// File: tb/tb_vx_perf_ctr_bank.sv
// Bench for vx_perf_ctr_bank: two 8-bit instances (wrap and saturate) share
// all stimulus; each has its own expected-response queue and monitor.
module tb_vx_perf_ctr_bank;

   localparam int unsigned NCH = 6;
   localparam int unsigned IW  = 4;
   localparam int unsigned CW  = 8;

   typedef struct {
      logic [CW-1:0] d;
      logic          o;
      int unsigned   c;
      int            id;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              enable;
   logic              clear;
   logic [NCH*IW-1:0] event_incr;
`ifdef VX_PERF_SNAPSHOT_EN
   logic              snap_req;
`endif
   logic              rd_req_valid;
   logic [2:0]        rd_req_id;
   logic              rd_rsp_ready;

   logic              wrap_req_ready, wrap_rsp_valid, wrap_rsp_ovf;
   logic [CW-1:0]     wrap_rsp_data;
   logic              sat_req_ready, sat_rsp_valid, sat_rsp_ovf;
   logic [CW-1:0]     sat_rsp_data;

   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        q_wrap[$];
   exp_t        q_sat[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vx_perf_ctr_bank #(
      .NUM_CHANNELS (NCH), .INCR_WIDTH (IW), .CTR_WIDTH (CW), .SATURATE (1'b0)
   ) u_wrap (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .clear        (clear),
      .event_incr   (event_incr),
`ifdef VX_PERF_SNAPSHOT_EN
      .snap_req     (snap_req),
`endif
      .rd_req_valid (rd_req_valid),
      .rd_req_id    (rd_req_id),
      .rd_req_ready (wrap_req_ready),
      .rd_rsp_valid (wrap_rsp_valid),
      .rd_rsp_data  (wrap_rsp_data),
      .rd_rsp_ovf   (wrap_rsp_ovf),
      .rd_rsp_ready (rd_rsp_ready)
   );

   vx_perf_ctr_bank #(
      .NUM_CHANNELS (NCH), .INCR_WIDTH (IW), .CTR_WIDTH (CW), .SATURATE (1'b1)
   ) u_sat (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .clear        (clear),
      .event_incr   (event_incr),
`ifdef VX_PERF_SNAPSHOT_EN
      .snap_req     (snap_req),
`endif
      .rd_req_valid (rd_req_valid),
      .rd_req_id    (rd_req_id),
      .rd_req_ready (sat_req_ready),
      .rd_rsp_valid (sat_rsp_valid),
      .rd_rsp_data  (sat_rsp_data),
      .rd_rsp_ovf   (sat_rsp_ovf),
      .rd_rsp_ready (rd_rsp_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_incr(input int ch, input int v);
      event_incr = '0;
      event_incr[ch*IW +: IW] = IW'(v);
   endtask

   // Stop counting and let the (optional) shadow catch up with live values
   task automatic idle();
      enable     = 1'b0;
      event_incr = '0;
      tick();
      tick();
   endtask

   // Issue one read with the response slot free; consumed on the next cycle
   task automatic rd(input int id, input int wd, input int wo, input int sd, input int so);
      chk("req_ready_wrap", 32'(wrap_req_ready), 32'd1);
      chk("req_ready_sat", 32'(sat_req_ready), 32'd1);
      rd_req_valid = 1'b1;
      rd_req_id    = 3'(id);
      q_wrap.push_back('{d: CW'(wd), o: 1'(wo), c: cyc + 1, id: id});
      q_sat.push_back('{d: CW'(sd), o: 1'(so), c: cyc + 1, id: id});
      tick();
      rd_req_valid = 1'b0;
   endtask

   // Wrap-instance response monitor
   always @(negedge clk) begin
      exp_t e;
      if (reset_n === 1'b1 && wrap_rsp_valid === 1'b1 && rd_rsp_ready === 1'b1) begin
         checks++;
         if (q_wrap.size() == 0) begin
            errors++;
            $display("FAIL wrap_rsp: unexpected response data=%0d ovf=%0d cycle %0d",
                     wrap_rsp_data, wrap_rsp_ovf, cyc);
         end else begin
            e = q_wrap.pop_front();
            if (wrap_rsp_data !== e.d || wrap_rsp_ovf !== e.o || cyc != e.c) begin
               errors++;
               $display("FAIL wrap_rsp id %0d: got data=%0d ovf=%0d cycle %0d expected data=%0d ovf=%0d cycle %0d",
                        e.id, wrap_rsp_data, wrap_rsp_ovf, cyc, e.d, e.o, e.c);
            end
         end
      end
   end

   // Saturate-instance response monitor
   always @(negedge clk) begin
      exp_t e;
      if (reset_n === 1'b1 && sat_rsp_valid === 1'b1 && rd_rsp_ready === 1'b1) begin
         checks++;
         if (q_sat.size() == 0) begin
            errors++;
            $display("FAIL sat_rsp: unexpected response data=%0d ovf=%0d cycle %0d",
                     sat_rsp_data, sat_rsp_ovf, cyc);
         end else begin
            e = q_sat.pop_front();
            if (sat_rsp_data !== e.d || sat_rsp_ovf !== e.o || cyc != e.c) begin
               errors++;
               $display("FAIL sat_rsp id %0d: got data=%0d ovf=%0d cycle %0d expected data=%0d ovf=%0d cycle %0d",
                        e.id, sat_rsp_data, sat_rsp_ovf, cyc, e.d, e.o, e.c);
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_n      = 1'b0;
      enable       = 1'b0;
      clear        = 1'b0;
      event_incr   = '0;
      rd_req_valid = 1'b0;
      rd_req_id    = '0;
      rd_rsp_ready = 1'b1;
`ifdef VX_PERF_SNAPSHOT_EN
      snap_req     = 1'b1;
`endif
      tick();
      tick();

      // Reset state
      chk("rst_rsp_valid_wrap", 32'(wrap_rsp_valid), 32'd0);
      chk("rst_rsp_data_wrap", 32'(wrap_rsp_data), 32'd0);
      chk("rst_rsp_ovf_wrap", 32'(wrap_rsp_ovf), 32'd0);
      chk("rst_req_ready_wrap", 32'(wrap_req_ready), 32'd1);
      chk("rst_rsp_valid_sat", 32'(sat_rsp_valid), 32'd0);
      chk("rst_rsp_data_sat", 32'(sat_rsp_data), 32'd0);
      reset_n = 1'b1;
      tick();

      // Basic accumulation: ch1 +1 and ch2 +3 for 10 cycles
      enable = 1'b1;
      event_incr = '0;
      event_incr[1*IW +: IW] = 4'd1;
      event_incr[2*IW +: IW] = 4'd3;
      for (int i = 0; i < 10; i++) tick();
      idle();
      rd(2, 30, 0, 30, 0);
      rd(0, 0, 0, 0, 0);
      rd(1, 10, 0, 10, 0);
      rd(3, 0, 0, 0, 0);
      rd(4, 0, 0, 0, 0);
      rd(5, 0, 0, 0, 0);
      rd(6, 0, 0, 0, 0);
      rd(7, 0, 0, 0, 0);

      // Response stall: slot drains, then a held response blocks new requests
      tick();
      chk("rsp_valid_drop_wrap", 32'(wrap_rsp_valid), 32'd0);
      chk("rsp_valid_drop_sat", 32'(sat_rsp_valid), 32'd0);
      rd_rsp_ready = 1'b0;
      rd_req_valid = 1'b1;
      rd_req_id    = 3'd2;
      q_wrap.push_back('{d: 8'd30, o: 1'b0, c: cyc + 6, id: 2});
      q_sat.push_back('{d: 8'd30, o: 1'b0, c: cyc + 6, id: 2});
      tick();
      rd_req_id = 3'd1;
      for (int i = 0; i < 5; i++) begin
         chk("stall_rsp_valid_wrap", 32'(wrap_rsp_valid), 32'd1);
         chk("stall_req_ready_wrap", 32'(wrap_req_ready), 32'd0);
         chk("stall_data_wrap", 32'(wrap_rsp_data), 32'd30);
         chk("stall_req_ready_sat", 32'(sat_req_ready), 32'd0);
         chk("stall_data_sat", 32'(sat_rsp_data), 32'd30);
         tick();
      end
      rd_rsp_ready = 1'b1;
      q_wrap.push_back('{d: 8'd10, o: 1'b0, c: cyc + 1, id: 1});
      q_sat.push_back('{d: 8'd10, o: 1'b0, c: cyc + 1, id: 1});
      tick();
      rd_req_valid = 1'b0;
      tick();

      // Overflow on ch0: 25 x 10 = 250, then +15
      enable = 1'b1;
      set_incr(0, 10);
      for (int i = 0; i < 25; i++) tick();
      idle();
      rd(0, 250, 0, 250, 0);
      enable = 1'b1;
      set_incr(0, 15);
      tick();
      idle();
      rd(0, 9, 1, 255, 1);
      enable = 1'b1;
      set_incr(0, 7);
      tick();
      idle();
      rd(0, 16, 1, 255, 1);

      // Clear with enable and increment in the same cycle as a read of ch3
      enable = 1'b1;
      set_incr(3, 5);
      for (int i = 0; i < 8; i++) tick();
      enable = 1'b0;
      tick();
      enable = 1'b1;
      clear  = 1'b1;
      set_incr(3, 5);
      rd(3, 40, 0, 40, 0);
      clear = 1'b0;
      idle();
      rd(3, 0, 0, 0, 0);
      rd(0, 0, 0, 0, 0);
      rd(2, 0, 0, 0, 0);
      rd(1, 0, 0, 0, 0);

`ifdef VX_PERF_SNAPSHOT_EN
      // Shadow bank: reads are frozen between snapshots
      snap_req = 1'b0;
      enable = 1'b1;
      set_incr(4, 10);
      for (int i = 0; i < 10; i++) tick();
      idle();
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      enable = 1'b1;
      set_incr(4, 10);
      tick();
      tick();
      idle();
      rd(4, 100, 0, 100, 0);
      rd(3, 0, 0, 0, 0);
      snap_req = 1'b1;
      rd(4, 100, 0, 100, 0);
      snap_req = 1'b0;
      rd(4, 120, 0, 120, 0);
      snap_req = 1'b1;
      clear    = 1'b1;
      tick();
      snap_req = 1'b0;
      clear    = 1'b0;
      tick();
      rd(4, 120, 0, 120, 0);
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      rd(4, 0, 0, 0, 0);
`endif

      // Drain outstanding responses within a bounded window
      for (int i = 0; i < 20 && (q_wrap.size() != 0 || q_sat.size() != 0); i++) tick();
      chk("drain_wrap", 32'(q_wrap.size()), 32'd0);
      chk("drain_sat", 32'(q_sat.size()), 32'd0);

      // Reset during a held response drops it immediately
      tick();
      rd_rsp_ready = 1'b0;
      rd_req_valid = 1'b1;
      rd_req_id    = 3'd1;
      tick();
      rd_req_valid = 1'b0;
      chk("pre_reset_rsp_valid_wrap", 32'(wrap_rsp_valid), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_reset_rsp_valid_wrap", 32'(wrap_rsp_valid), 32'd0);
      chk("async_reset_rsp_valid_sat", 32'(sat_rsp_valid), 32'd0);
      chk("async_reset_req_ready_wrap", 32'(wrap_req_ready), 32'd1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
